// File: rtl/spi_config_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_config_master_pkg
//   Shared SNN configuration package. Holds the SPI configuration master FSM
//   encoding, frame limits and the byte map of the 80-byte configuration
//   image that the master streams into the SNN core.
// ---------------------------------------------------------------------------
package spi_config_master_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned FRAME_BYTES_MAX = 255;

  // Master FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_HOLD     = 3'd4,
    ST_DONE     = 3'd5
  } spi_state_t;

  // Configuration image byte map (offset / length in bytes).
  localparam int unsigned CFG_DECAY_OFS      = 0;
  localparam int unsigned CFG_DECAY_LEN      = 1;
  localparam int unsigned CFG_REFRACTORY_OFS = 1;
  localparam int unsigned CFG_REFRACTORY_LEN = 1;
  localparam int unsigned CFG_THRESHOLD_OFS  = 2;
  localparam int unsigned CFG_THRESHOLD_LEN  = 2;
  localparam int unsigned CFG_DIV_VALUE_OFS  = 4;
  localparam int unsigned CFG_DIV_VALUE_LEN  = 2;
  localparam int unsigned CFG_WEIGHTS_OFS    = 6;
  localparam int unsigned CFG_WEIGHTS_LEN    = 32;
  localparam int unsigned CFG_DELAYS_OFS     = 38;
  localparam int unsigned CFG_DELAYS_LEN     = 32;
  localparam int unsigned CFG_DEBUG_OFS      = 70;
  localparam int unsigned CFG_DEBUG_LEN      = 10;
  localparam int unsigned CFG_TOTAL_BYTES    = 80;

  // A frame request is only meaningful with at least one byte to send.
  function automatic logic frame_len_ok(input logic [BYTE_W-1:0] len);
    return len != '0;
  endfunction

endpackage

// File: rtl/spi_config_master_if.sv
// ---------------------------------------------------------------------------
// spi_config_master_if
//   Bundles the host-side byte stream handshake, the frame control/status
//   signals and the four SPI pins of spi_config_master.
//   master : view taken by spi_config_master itself
//   slave  : view taken by the host / SPI peripheral model driving it
// ---------------------------------------------------------------------------
interface spi_config_master_if;
  logic       start;      // one-cycle frame request
  logic [7:0] frame_len;  // bytes in the frame, captured on accepted start
  logic [7:0] tx_data;    // next byte to transmit
  logic       tx_valid;
  logic       tx_ready;   // high only while waiting for the next byte
  logic [7:0] rx_data;    // byte assembled from miso
  logic       rx_valid;   // one-cycle pulse
  logic       busy;
  logic       done;       // one-cycle pulse at frame end
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;

  modport master (
    input  start, frame_len, tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, ss
  );

  modport slave (
    output start, frame_len, tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, busy, done, sclk, mosi, ss
  );
endinterface

// File: rtl/spi_shift_reg.sv
// ---------------------------------------------------------------------------
// spi_shift_reg
//   Single 8-bit register shared by the transmit and receive paths. A byte is
//   parallel-loaded, then shifted left once per bit; the vacated LSB takes
//   the miso bit captured earlier in the same bit period, so after eight
//   shifts the register holds the received byte.
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   load        : parallel-load load_data
//   load_data   : byte to transmit
//   sample      : capture miso (first cycle of SCLK high)
//   shift       : shift left, inserting the captured miso bit
//   miso        : serial input
//   shifted     : register value after the next shift (received byte on the
//                 last bit of a byte)
//   next_bit    : bit that reaches the MSB (next mosi value) on the next shift
// ---------------------------------------------------------------------------
module spi_shift_reg
  import spi_config_master_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BYTE_W-1:0] load_data,
  input  logic              sample,
  input  logic              shift,
  input  logic              miso,
  output logic [BYTE_W-1:0] shifted,
  output logic              next_bit
);

  logic [BYTE_W-1:0] data;
  logic              miso_bit;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      data     <= '0;
      miso_bit <= 1'b0;
    end else begin
      if (load) begin
        data <= load_data;
      end else if (shift) begin
        data <= shifted;
      end
      // miso is captured on SCLK rise but only folded in on SCLK fall, so the
      // MSB driving mosi stays put for the whole high phase.
      if (sample) begin
        miso_bit <= miso;
      end
    end
  end

  assign shifted  = {data[BYTE_W-2:0], miso_bit};
  assign next_bit = data[BYTE_W-2];

endmodule

// File: rtl/spi_config_master.sv
// ---------------------------------------------------------------------------
// spi_config_master
//   SPI mode-0 master that streams a frame of frame_len bytes (MSB first)
//   from the host byte stream onto mosi while assembling the bytes returned
//   on miso. SS stays low for the whole frame, including the hold phase after
//   the last byte; SCLK is parked low whenever the host has not supplied the
//   next byte.
// Parameters
//   HALF_PERIOD : system_clock cycles per SCLK phase, legal 2..255
// Ports
//   system_clock : single rising-edge clock
//   reset        : synchronous active-high reset, aborts any frame
//   bus          : spi_config_master_if.master (handshake, status, SPI pins)
// ---------------------------------------------------------------------------
module spi_config_master
  import spi_config_master_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic                system_clock,
  input  logic                reset,
  spi_config_master_if.master bus
);

  // Every phase lasts HALF_PERIOD cycles: the counter reloads to N-1 on
  // entry and the phase ends on the cycle it reads zero.
  localparam logic [7:0] HP_RELOAD = 8'(HALF_PERIOD - 1);

  spi_state_t  state;
  logic [7:0]  hp_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;
  logic [7:0]  frame_len_q;

  logic        ss_q;
  logic        sclk_q;
  logic        mosi_q;
  logic        tx_ready_q;
  logic        rx_valid_q;
  logic        done_q;
  logic        busy_q;
  logic [7:0]  rx_data_q;

  logic        sr_load;
  logic        sr_sample;
  logic        sr_shift;
  logic [7:0]  sr_shifted;
  logic        sr_next_bit;
  logic        phase_last;
  logic        last_byte;

  assign phase_last = (hp_cnt == 8'd0);
  assign last_byte  = ((byte_cnt + 8'd1) >= frame_len_q);

  // Shift register strobes. Sampling on the first high cycle is unambiguous
  // because HALF_PERIOD >= 2 keeps HP_RELOAD distinct from zero.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    sr_load   = 1'b0;
    sr_sample = 1'b0;
    sr_shift  = 1'b0;
    unique case (state)
      ST_LOAD: begin
        sr_load = bus.tx_valid;
      end
      ST_SHIFT_HI: begin
        sr_sample = (hp_cnt == HP_RELOAD);
        sr_shift  = phase_last;
      end
      default: ;
    endcase
  end

  spi_shift_reg u_shift_reg (
    .clk       (system_clock),
    .reset     (reset),
    .load      (sr_load),
    .load_data (bus.tx_data),
    .sample    (sr_sample),
    .shift     (sr_shift),
    .miso      (bus.miso),
    .shifted   (sr_shifted),
    .next_bit  (sr_next_bit)
  );

  // Single FSM process; all pin and status outputs are registered and set on
  // the transition into the state that owns them.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      hp_cnt      <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      frame_len_q <= '0;
      ss_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          // frame_len is captured here only; later changes are ignored.
          if (bus.start && frame_len_ok(bus.frame_len)) begin
            state       <= ST_LOAD;
            frame_len_q <= bus.frame_len;
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            busy_q      <= 1'b1;
            ss_q        <= 1'b0;
            tx_ready_q  <= 1'b1;
          end
        end

        ST_LOAD: begin
          // Without tx_valid the bus simply idles here with SS low and
          // SCLK low for as long as the host needs.
          if (bus.tx_valid) begin
            state      <= ST_SHIFT_LO;
            tx_ready_q <= 1'b0;
            mosi_q     <= bus.tx_data[7];
            hp_cnt     <= HP_RELOAD;
          end
        end

        ST_SHIFT_LO: begin
          if (phase_last) begin
            state  <= ST_SHIFT_HI;
            sclk_q <= 1'b1;
            hp_cnt <= HP_RELOAD;
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end

        ST_SHIFT_HI: begin
          if (phase_last) begin
            sclk_q  <= 1'b0;
            hp_cnt  <= HP_RELOAD;
            bit_cnt <= bit_cnt + 3'd1;  // wraps 7 -> 0 at byte end
            if (bit_cnt != 3'd7) begin
              state  <= ST_SHIFT_LO;
              mosi_q <= sr_next_bit;
            end else begin
              rx_valid_q <= 1'b1;
              rx_data_q  <= sr_shifted;
              byte_cnt   <= byte_cnt + 8'd1;
              if (last_byte) begin
                state <= ST_HOLD;
              end else begin
                state      <= ST_LOAD;
                tx_ready_q <= 1'b1;
              end
            end
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end

        ST_HOLD: begin
          // SS hold time after the final SCLK fall.
          if (phase_last) begin
            state  <= ST_DONE;
            ss_q   <= 1'b1;
            done_q <= 1'b1;
          end else begin
            hp_cnt <= hp_cnt - 8'd1;
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          mosi_q <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ss       = ss_q;
  assign bus.sclk     = sclk_q;
  assign bus.mosi     = mosi_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_spi_config_master.sv
// ---------------------------------------------------------------------------
// tb_spi_config_master
//   Randomised scoreboard bench for spi_config_master. The stimulus process
//   pushes the expected received byte and the expected mosi byte at each
//   tx handshake; a negedge monitor acts as the SPI slave, pops and compares
//   on every completed mosi byte and every rx_valid pulse, and watches the
//   pin-level rules of the frame.
// ---------------------------------------------------------------------------
module tb_spi_config_master;
  import spi_config_master_pkg::*;

  localparam int HP = 4;

  typedef struct {
    logic [7:0] data;
    int         hs_cyc;
  } exp_t;

  logic system_clock = 1'b0;
  logic reset;
  bit   miso_mode;     // 0: miso looped back from mosi, 1: miso tied high
  bit   abort_window;  // set around a deliberate mid-byte reset

  always #5 system_clock = ~system_clock;

  spi_config_master_if bus ();

  assign bus.miso = miso_mode ? 1'b1 : bus.mosi;

  spi_config_master #(.HALF_PERIOD(HP)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  always @(posedge system_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard queues and counters
  exp_t       exp_rx[$];
  logic [7:0] exp_mosi[$];
  logic [7:0] slave_log[$];
  logic [7:0] frame_bytes[$];
  int rises = 0, rx_cnt = 0, done_cnt = 0, hs_cnt = 0, proto_err = 0;

  // Monitor / slave model state
  logic       sclk_prev = 1'b0, mosi_prev = 1'b0, rxv_prev = 1'b0, done_prev = 1'b0;
  logic [7:0] slv_shift = '0;
  int         slv_bits = 0, hi_run = 0;
  exp_t       mon_e;

  always @(negedge system_clock) begin
    if (bus.ss === 1'b1) slv_bits = 0;
    if (bus.sclk === 1'b1 && !sclk_prev) begin
      rises++;
      slv_shift = {slv_shift[6:0], bus.mosi};
      slv_bits++;
      if (slv_bits == 8) begin
        slv_bits = 0;
        slave_log.push_back(slv_shift);
        if (exp_mosi.size() == 0) check("mosi_queue_depth", 0, 1);
        else check("mosi_byte", slv_shift, exp_mosi.pop_front());
      end
    end
    if (bus.sclk === 1'b1) begin
      hi_run++;
    end else begin
      if (sclk_prev && !abort_window) check("sclk_high_cycles", hi_run, HP);
      hi_run = 0;
    end
    // Pin-level rules of a mode-0 frame
    if (bus.sclk === 1'b1 && sclk_prev && bus.mosi !== mosi_prev) proto_err++;
    if (bus.sclk === 1'b1 && bus.ss === 1'b1) proto_err++;
    if (bus.busy === 1'b1 && bus.done !== 1'b1 && bus.ss !== 1'b0) proto_err++;
    if (bus.tx_ready === 1'b1 && (bus.sclk !== 1'b0 || bus.ss !== 1'b0)) proto_err++;
    if (bus.busy === 1'b0 && (bus.tx_ready !== 1'b0 || bus.ss !== 1'b1 ||
                              bus.sclk !== 1'b0 || bus.mosi !== 1'b0)) proto_err++;
    if (bus.rx_valid === 1'b1 && rxv_prev) proto_err++;
    if (bus.done === 1'b1 && done_prev) proto_err++;
    if (bus.rx_valid === 1'b1) begin
      rx_cnt++;
      if (exp_rx.size() == 0) begin
        check("rx_queue_depth", 0, 1);
      end else begin
        mon_e = exp_rx.pop_front();
        check("rx_data", bus.rx_data, mon_e.data);
        check("rx_latency", cyc - mon_e.hs_cyc, 16 * HP + 1);
      end
    end
    if (bus.done === 1'b1) done_cnt++;
    sclk_prev = (bus.sclk === 1'b1);
    mosi_prev = bus.mosi;
    rxv_prev  = (bus.rx_valid === 1'b1);
    done_prev = (bus.done === 1'b1);
  end

  // Offer one byte and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b);
    int   waited = 0;
    exp_t e;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && waited < 2000) begin
      @(negedge system_clock);
      waited++;
    end
    if (bus.tx_ready !== 1'b1) begin
      check("tx_ready_timeout", bus.tx_ready, 1);
      bus.tx_valid = 1'b0;
      return;
    end
    hs_cnt++;
    e.data   = miso_mode ? 8'hFF : b;
    e.hs_cyc = cyc;
    exp_rx.push_back(e);
    exp_mosi.push_back(b);
    @(negedge system_clock);
    bus.tx_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] len);
    bus.frame_len = len;
    bus.start     = 1'b1;
    @(negedge system_clock);
    bus.start     = 1'b0;
    bus.frame_len = 8'($urandom);
  endtask

  // Send frame_bytes as one frame and check the frame-level totals.
  task automatic run_frame(input int stall_at, input int stall_len, input bit mid_start);
    int len    = frame_bytes.size();
    int rises0 = rises, done0 = done_cnt, rx0 = rx_cnt, hs0 = hs_cnt;
    slave_log.delete();
    pulse_start(8'(len));
    foreach (frame_bytes[i]) begin
      if (i == stall_at) repeat (stall_len) @(negedge system_clock);
      send_byte(frame_bytes[i]);
      if (mid_start && i == 0) pulse_start(8'($urandom_range(1, 255)));
    end
    for (int w = 0; w < 5000 && done_cnt == done0; w++) @(negedge system_clock);
    repeat (3) @(negedge system_clock);
    check("frame_done_count", done_cnt - done0, 1);
    check("frame_sclk_rises", rises - rises0, 8 * len);
    check("frame_handshakes", hs_cnt - hs0, len);
    check("frame_rx_count", rx_cnt - rx0, len);
    check("frame_slave_bytes", slave_log.size(), len);
    check("frame_rx_pending", exp_rx.size(), 0);
    check("frame_busy_after", bus.busy, 0);
    check("frame_ss_after", bus.ss, 1);
  endtask

  initial begin
    int rises0, done0, rx0, n;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.tx_data   = '0;
    bus.tx_valid  = 1'b0;
    miso_mode     = 1'b0;
    abort_window  = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge system_clock);
    check("reset_ss", bus.ss, 1);
    check("reset_sclk", bus.sclk, 0);
    check("reset_mosi", bus.mosi, 0);
    check("reset_tx_ready", bus.tx_ready, 0);
    check("reset_rx_valid", bus.rx_valid, 0);
    check("reset_rx_data", bus.rx_data, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    reset = 1'b0;
    repeat (2) @(negedge system_clock);

    // Single 0xA5 byte, loopback
    frame_bytes = {8'hA5};
    run_frame(-1, 0, 1'b0);
    check("a5_mosi_byte", slave_log[0], 8'hA5);

    // miso tied high, two bytes
    miso_mode = 1'b1;
    frame_bytes = {8'($urandom), 8'($urandom)};
    run_frame(-1, 0, 1'b0);
    miso_mode = 1'b0;

    // Full configuration image 0..79
    frame_bytes.delete();
    for (int i = 0; i < int'(CFG_TOTAL_BYTES); i++) frame_bytes.push_back(8'(i));
    run_frame(-1, 0, 1'b0);
    check("cfg_first_byte", slave_log[0], 8'd0);
    check("cfg_top_byte", slave_log[CFG_TOTAL_BYTES-1], 8'(CFG_TOTAL_BYTES - 1));

    // Host stalls 20 cycles before the second byte
    frame_bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
    run_frame(1, 20, 1'b0);

    // Zero-length request is ignored
    done0 = done_cnt;
    pulse_start(8'd0);
    repeat (10) @(negedge system_clock);
    check("len0_busy", bus.busy, 0);
    check("len0_tx_ready", bus.tx_ready, 0);
    check("len0_done", done_cnt - done0, 0);

    // start pulsed while busy is ignored
    frame_bytes = {8'($urandom), 8'($urandom)};
    run_frame(-1, 0, 1'b1);

    // Reset during bit 4 of byte 2
    frame_bytes = {8'($urandom), 8'($urandom), 8'($urandom)};
    rises0 = rises; done0 = done_cnt; rx0 = rx_cnt;
    pulse_start(8'd3);
    send_byte(frame_bytes[0]);
    send_byte(frame_bytes[1]);
    for (int w = 0; w < 1000 && rises < rises0 + 12; w++) @(negedge system_clock);
    check("abort_reached_bit4", bus.sclk, 1);
    abort_window = 1'b1;
    reset = 1'b1;
    @(negedge system_clock);
    check("abort_ss", bus.ss, 1);
    check("abort_sclk", bus.sclk, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_tx_ready", bus.tx_ready, 0);
    check("abort_rx_data", bus.rx_data, 0);
    reset = 1'b0;
    exp_rx.delete();
    exp_mosi.delete();
    repeat (40 * HP) @(negedge system_clock);
    check("abort_no_done", done_cnt - done0, 0);
    check("abort_rx_count", rx_cnt - rx0, 1);
    abort_window = 1'b0;
    frame_bytes = {8'($urandom), 8'($urandom)};
    run_frame(-1, 0, 1'b0);

    // Random frames
    for (int f = 0; f < 6; f++) begin
      miso_mode = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 5);
      frame_bytes.delete();
      for (int i = 0; i < n; i++) frame_bytes.push_back(8'($urandom));
      run_frame($urandom_range(0, n - 1), $urandom_range(0, 12), 1'(f % 2));
    end

    check("protocol_violations", proto_err, 0);
    check("mosi_pending", exp_mosi.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/spi_config_master.md
SPI_CONFIG_MASTER -- requirements
Module: spi_config_master

Interface
REQ-001 Parameter: HALF_PERIOD, default 4, meaning system_clock cycles per SCLK phase; legal range 2..255.
REQ-002 system_clock  in  1  single clock; all flops rise-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle frame request; sampled only in IDLE.
REQ-005 frame_len  in  8  frame length in bytes; 1..255; captured on accepted start.
REQ-006 tx_data  in  8  next byte to transmit.
REQ-007 tx_valid  in  1  tx_data valid.
REQ-008 tx_ready  out  1  module accepts tx_data this cycle.
REQ-009 rx_data  out  8  byte shifted in from MISO.
REQ-010 rx_valid  out  1  one-cycle pulse; rx_data valid.
REQ-011 busy  out  1  high from accepted start until return to IDLE.
REQ-012 done  out  1  one-cycle pulse at frame end.
REQ-013 SCLK, MOSI, SS  out  1 each  SPI master pins; MISO  in  1.

Function
REQ-014 SPI mode 0: SCLK idles low; MOSI changes only while SCLK low; MISO sampled in the cycle SCLK rises; MSB first.
REQ-015 States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, HOLD, DONE.
REQ-016 IDLE: SS=1, SCLK=0, MOSI=0, busy=0; start=1 with frame_len!=0 -> LOAD and capture frame_len; start with frame_len=0 ignored.
REQ-017 LOAD: SS=0, SCLK=0, tx_ready=1; on tx_valid load tx_data into shift register, MOSI=bit7 next cycle, -> SHIFT_LO; without tx_valid stay in LOAD, SS held low, SCLK held low indefinitely.
REQ-018 SHIFT_LO: SCLK=0 for HALF_PERIOD cycles, then -> SHIFT_HI.
REQ-019 SHIFT_HI: SCLK=1 for HALF_PERIOD cycles; MISO shifted into rx register on entry cycle; on exit, if bit count<8 shift MOSI to next bit and -> SHIFT_LO.
REQ-020 After 8th SHIFT_HI: rx_valid pulses one cycle with the assembled byte; byte counter increments; if bytes sent<frame_len -> LOAD, else -> HOLD.
REQ-021 HOLD: SS=0, SCLK=0 for HALF_PERIOD cycles (SS hold time), then -> DONE.
REQ-022 DONE: SS=1, done=1 for one cycle, busy=0 next cycle, -> IDLE.
REQ-023 tx_ready is high only in LOAD; a byte is consumed exactly when tx_valid&&tx_ready.
REQ-024 start while busy ignored; frame_len changes while busy have no effect.
REQ-025 Half-period counter 8-bit, reloads to HALF_PERIOD-1 on every phase entry; bit counter 3-bit wraps 7->0 at byte end; byte counter 8-bit.
REQ-026 One full byte at zero stall = 16*HALF_PERIOD+1 cycles from LOAD handshake to rx_valid.

Reset
REQ-027 reset forces IDLE in the next cycle from any state, mid-byte included: SS=1, SCLK=0, MOSI=0, tx_ready=0, rx_valid=0, done=0, busy=0, rx_data=0, all counters 0.
REQ-028 A frame aborted by reset produces no done and no partial rx_valid.

Structure
REQ-029 State encoding and FRAME_BYTES_MAX=255 constant reside in the shared SNN configuration package, alongside the configuration byte-map constants (decay, refractory, threshold, div_value, weights, delays, debug offsets, 80-byte total).
REQ-030 One sub-module natural: spi_shift_reg (8-bit load/shift-out/shift-in register); FSM and counters in top level.

Verification
REQ-031 HALF_PERIOD=4, frame_len=1, tx_data=0xA5, MISO loopback from MOSI -> SCLK 8 pulses of 8 cycles, MOSI bits 1,0,1,0,0,1,0,1, rx_data=0xA5 with rx_valid, done once, SS low throughout.
REQ-032 frame_len=80 streaming bytes 0..79 into a model SPI receiver slave -> receiver holds all 80 bytes, byte 79 at top byte lane, exactly 80 tx handshakes, one done.
REQ-033 frame_len=3, tx_valid withheld 20 cycles before byte 2 -> SCLK held low, SS stays low, byte stream unchanged, no extra SCLK edge.
REQ-034 reset asserted during bit 4 of byte 2 -> next cycle SS=1, SCLK=0, busy=0; no done; new start then completes normally.
REQ-035 start with frame_len=0, and start pulsed while busy -> no state change, no extra done.
REQ-036 MISO tied 1, frame_len=2 -> two rx_valid pulses with rx_data=0xFF.
